chunked_serial_adder: RTL

Multi-cycle N-bit adder/subtractor that processes operands CHUNK bits per clock, LSB chunk first, carrying between chunks in a register. It is the parametrised successor of our combinational ripple adder and serves the sequential multiplier datapath where wide operands must not produce a WIDTH-long carry chain in one cycle. It adds a subtract mode, signed-overflow detection and valid/ready handshakes on both sides.

---
 rtl/adder_pkg.sv | 19 +
 rtl/chunk_adder.sv | 30 +++
 rtl/full_adder.sv | 13 +
 rtl/chunked_serial_adder.sv | 96 +++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the chunked serial adder and the multiplier control.
package adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int nchunk(input int width, input int chunk);
      return width / chunk;
   endfunction

   // A counter over a single chunk still needs one bit to exist.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/chunk_adder.sv
// CHUNK-bit combinational ripple adder built from full_adder cells.
module chunk_adder #(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             ci,
   output logic [CHUNK-1:0] s,
   output logic             co,
   output logic             c_msb
);

   logic [CHUNK:0] c;

   assign c[0] = ci;

   for (genvar i = 0; i < CHUNK; i++) begin : g_fa
      full_adder u_fa (
         .a  (a[i]),
         .b  (b[i]),
         .ci (c[i]),
         .s  (s[i]),
         .co (c[i+1])
      );
   end

   assign co    = c[CHUNK];
   assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/chunked_serial_adder.sv
// Multi-cycle adder/subtractor: CHUNK bits per clock, LSB chunk first.
module chunked_serial_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   input  logic             sub,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             overflow
);

   localparam int NCHUNK = nchunk(WIDTH, CHUNK);
   localparam int IW     = idx_width(NCHUNK);
   localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

   state_t           state_q;
   state_t           state_d;
   logic [IW-1:0]    idx_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             carry_q;
   logic [CHUNK-1:0] ch_sum;
   logic             ch_co;
   logic             ch_cmsb;
   logic             accept;
   logic             last;
   int               base;

   assign start_ready = (state_q == IDLE);
   assign res_valid   = (state_q == DONE);
   assign accept      = start_valid && start_ready;
   assign last        = (idx_q == LAST);
   assign base        = int'(idx_q) * CHUNK;

   chunk_adder #(.CHUNK(CHUNK)) u_chunk (
      .a     (a_q[base +: CHUNK]),
      .b     (b_q[base +: CHUNK]),
      .ci    (carry_q),
      .s     (ch_sum),
      .co    (ch_co),
      .c_msb (ch_cmsb)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start_valid) state_d = RUN;
         RUN:     if (last) state_d = DONE;
         DONE:    if (res_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Subtraction is a + ~b + 1, so the carry register seeds the +1.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idx_q    <= '0;
         carry_q  <= 1'b0;
         sum      <= '0;
         c_out    <= 1'b0;
         overflow <= 1'b0;
      end else if (accept) begin
         a_q     <= a;
         b_q     <= sub ? ~b : b;
         carry_q <= sub | c_in;
         idx_q   <= '0;
      end else if (state_q == RUN) begin
         sum[base +: CHUNK] <= ch_sum;
         carry_q            <= ch_co;
         if (last) begin
            idx_q    <= '0;
            c_out    <= ch_co;
            overflow <= ch_cmsb ^ ch_co;
         end else begin
            idx_q <= idx_q + 1'b1;
         end
      end
   end

endmodule
